// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserializer with start-marker framing and one-word output holding register
// Optional: define SIPO_PARITY_EN to consume and check a trailing even-parity bit per frame.
module sipo_deser #(
    parameter int DATA_WIDTH = 16,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  din_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow,
    output logic                  parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {HUNT, SHIFT} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [DATA_WIDTH-1:0] sr, sr_next;
    logic [DATA_WIDTH-1:0] shift_base, shifted, done_word;
    logic                  restart, take, frame_done, data_bit, word_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= HUNT;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sr    <= sr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        restart    = din_valid && din_start;
        take       = din_valid && (state == SHIFT || din_start);
        frame_done = take && !restart && (cnt == CW'(FRAME_LEN - 1));
`ifdef SIPO_PARITY_EN
        // The final bit of a frame is parity and never enters the data register.
        data_bit   = restart || (cnt < CW'(DATA_WIDTH));
        word_ok    = (din == ^sr);
        done_word  = sr;
`else
        data_bit   = 1'b1;
        word_ok    = 1'b1;
        done_word  = '0;
`endif
        // A start marker discards any partial word before this bit enters.
        shift_base = restart ? '0 : sr;
        if (MSB_FIRST != 0) begin
            shifted = {shift_base[DATA_WIDTH-2:0], din};
        end else begin
            shifted = {din, shift_base[DATA_WIDTH-1:1]};
        end
`ifndef SIPO_PARITY_EN
        done_word  = shifted;
`endif
        if (restart) begin
            state_next = SHIFT;
            cnt_next   = CW'(1);
            sr_next    = shifted;
        end else if (take) begin
            if (data_bit) begin
                sr_next = shifted;
            end
            cnt_next = frame_done ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (frame_done && word_ok) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= done_word;
                    dout_valid <= 1'b1;
                end else begin
                    overflow   <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= frame_done && !word_ok;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - randomized self-checking bench for sipo_deser against a bit-queue reference model
module tb_sipo_deser;
    localparam int DW  = 16;
    localparam int MSB = 0;
`ifdef SIPO_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_start = 1'b0;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          overflow;
    logic          parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic          m_sync;
    logic          m_bits[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_perr;

    always #5 clk = ~clk;

    sipo_deser #(.DATA_WIDTH(DW), .MSB_FIRST(MSB)) dut (
        .clk(clk),
        .resetn(resetn),
        .din(din),
        .din_valid(din_valid),
        .din_start(din_start),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overflow(overflow),
        .parity_err(parity_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_sync = 1'b0;
        m_bits.delete();
        m_dout = '0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_perr = 1'b0;
    endfunction

    // Frames are collected as a list of received bits and only turned into a word once complete.
    function automatic void model_step(input logic d, input logic v, input logic s, input logic r);
        logic          done;
        logic          ok;
        logic          par;
        logic [DW-1:0] w;
        done = 1'b0;
        ok = 1'b1;
        par = 1'b0;
        w = '0;
        if (v) begin
            if (s) begin
                m_sync = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
            end else if (m_sync) begin
                m_bits.push_back(d);
            end
            if (m_bits.size() == FL) begin
                done = 1'b1;
                for (int i = 0; i < DW; i++) begin
                    w[(MSB != 0) ? DW - 1 - i : i] = m_bits[i];
                    par ^= m_bits[i];
                end
                if (FL > DW) ok = (m_bits[DW] == par);
                m_bits.delete();
            end
        end
        m_perr = done && !ok;
        if (done && ok) begin
            if (!m_valid || r) begin
                m_dout = w;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic check_outputs();
        check_eq("dout_valid", dout_valid, m_valid);
        check_eq("dout", dout, m_dout);
        check_eq("overflow", overflow, m_ovf);
        check_eq("parity_err", parity_err, m_perr);
    endtask

    task automatic cycle(input logic d, input logic v, input logic s, input logic r);
        din = d;
        din_valid = v;
        din_start = s;
        dout_ready = r;
        @(posedge clk);
        model_step(d, v, s, r);
        #1;
        check_outputs();
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input logic pbit, input logic r,
                             input logic gaps, input logic first_start);
        logic d;
        for (int i = 0; i < FL; i++) begin
            d = (i < DW) ? w[i] : pbit;
            cycle(d, 1'b1, first_start && (i == 0), r);
            if (gaps) cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), r);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input logic r, input logic gaps, input logic first_start);
        send_bits(w, ^w, r, gaps, first_start);
    endtask

    task automatic do_reset();
        #3;
        resetn = 1'b0;
        #1;
        check_eq("rst_dout", dout, '0);
        check_eq("rst_dout_valid", dout_valid, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_parity_err", parity_err, 1'b0);
        model_reset();
        din_valid = 1'b0;
        din_start = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        send_frame(16'hA5C3, 1'b1, 1'b0, 1'b1);
        check_eq("t1_dout", dout, 16'hA5C3);
        check_eq("t1_valid", dout_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(16'hA5C3, 1'b1, 1'b1, 1'b1);
        check_eq("t2_dout", dout, 16'hA5C3);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, i == 0, 1'b1);
        send_frame(16'h00FF, 1'b1, 1'b0, 1'b1);
        check_eq("t4_dout", dout, 16'h00FF);
        check_eq("t4_ovf", overflow, 1'b0);

        send_frame(16'h0001, 1'b1, 1'b0, 1'b1);
        check_eq("t5_w0", dout, 16'h0001);
        send_frame(16'h8000, 1'b1, 1'b0, 1'b0);
        check_eq("t5_w1", dout, 16'h8000);
        send_frame(16'h5555, 1'b1, 1'b0, 1'b0);
        check_eq("t5_w2", dout, 16'h5555);
        check_eq("t5_ovf", overflow, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
        send_bits(16'h0003, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("p_ok_dout", dout, 16'h0003);
        check_eq("p_ok_perr", parity_err, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("p_bad_perr", parity_err, 1'b1);
        check_eq("p_bad_valid", dout_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("p_bad_pulse_end", parity_err, 1'b0);
`endif

        send_frame(16'h1234, 1'b0, 1'b0, 1'b1);
        send_frame(16'hBEEF, 1'b0, 1'b0, 1'b0);
        check_eq("t3_dout", dout, 16'h1234);
        check_eq("t3_ovf", overflow, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_consumed", dout_valid, 1'b0);
        check_eq("t3_dout_hold", dout, 16'h1234);

        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, i == 0, 1'b0);
        do_reset();
        send_frame(16'hCAFE, 1'b1, 1'b0, 1'b0);
        check_eq("hunt_no_word", dout_valid, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer.
- Consumes the 1-bit LSB-first stream produced by the team's PISO shifter and reassembles DATA_WIDTH-bit words.
- Presents each word on a valid/ready output port with a one-word holding register.
- Tracks frame alignment from a start marker and flags words lost to back-pressure.

Parameters:
- DATA_WIDTH, 16, word width in bits; legal range 2..64.
- MSB_FIRST, 0, 0 = first received bit lands in dout[0] (matches the PISO shifter); 1 = first bit lands in dout[DATA_WIDTH-1].

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- resetn  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a valid bit this cycle.
- din_start  input  1  qualified by din_valid; marks din as bit 0 of a new frame.
- dout  output  DATA_WIDTH  assembled word; stable while dout_valid=1 and dout_ready=0.
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  downstream accepts the word when dout_valid && dout_ready.
- overflow  output  1  sticky flag: a completed word was dropped.
- parity_err  output  1  one-cycle pulse on parity failure; tied 0 unless SIPO_PARITY_EN is defined.

Behaviour:
- Reset (resetn=0, async):
  - shift register = 0, bit counter = 0.
  - dout = 0, dout_valid = 0, overflow = 0, parity_err = 0.
  - sync flag = 0 (state HUNT).
- States:
  - HUNT: ignore bits until din_valid && din_start, then go to SHIFT. That bit is bit 0 and counter becomes 1.
  - SHIFT: each din_valid bit shifts in and increments the counter.
  - din_valid=0: counter and shift register hold (stall, any length).
- Frame complete: the bit with counter = FRAME_LEN-1 is received.
  - FRAME_LEN = DATA_WIDTH, or DATA_WIDTH+1 with parity.
  - Word = shift register including that bit.
  - Counter wraps to 0; state stays SHIFT. The next frame may start on the next cycle without a start marker.
- Latency: dout_valid rises on the clock edge that samples the last bit. It is visible the cycle after the last bit is presented.
- Load rule at frame complete:
  - If dout_valid=0, or (dout_valid && dout_ready) in the same cycle: load dout, dout_valid=1. Back-to-back throughput is one word per FRAME_LEN valid bits with no bubble.
  - If dout_valid=1 && dout_ready=0: new word is discarded, dout unchanged, overflow set to 1 (sticky until reset).
- Handshake: dout_valid && dout_ready with no new frame completing clears dout_valid next cycle; dout keeps its last value.
- din_start asserted in SHIFT with counter != 0:
  - Partial word is discarded without an error.
  - Counter restarts at 1 with this bit as bit 0.
- din_start asserted with counter == 0: normal frame start.
- din_start without din_valid: ignored.
- Bit placement:
  - MSB_FIRST=0: shift right, new bit enters at bit DATA_WIDTH-1, so the first bit ends at bit 0.
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
- Reset mid-frame: partial word is lost and the block returns to HUNT; the first frame after reset needs din_start.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - FRAME_LEN = DATA_WIDTH+1; the extra final bit is even parity over the data bits.
  - Mismatch: word is not loaded, dout_valid is unaffected, overflow is unaffected, and parity_err pulses high for exactly one cycle after the frame-complete edge.
  - Match: normal load rule applies.
- Undefined: FRAME_LEN = DATA_WIDTH, no parity bit consumed, parity_err constant 0.

Test Plan:
- Reset, then din_start on the first bit and 16 bits of 0xA5C3 LSB-first with din_valid=1 and dout_ready=1 -> dout=0xA5C3, dout_valid high for one cycle, overflow=0.
- Same word with din_valid toggled 1/0 every cycle -> dout=0xA5C3 after 32 cycles, no corruption.
- dout_ready=0; send 0x1234 then 0xBEEF back-to-back -> dout stays 0x1234, overflow=1; raise dout_ready -> 0x1234 consumed, dout_valid=0.
- Send 5 bits of 0xFFFF, then din_start with 16 bits of 0x00FF -> single output 0x00FF, no overflow.
- dout_ready=1 continuously; three back-to-back frames 0x0001, 0x8000, 0x5555 with no gaps -> three words, dout_valid high on the three completion edges, no overflow.
- SIPO_PARITY_EN defined; send 0x0003 with parity 0 -> accepted. Send 0x0007 with parity 0 -> parity_err one-cycle pulse, no dout_valid. Assert resetn=0 mid-frame -> all outputs 0 immediately.
